// File: rtl/regs_bank_v2.sv
// Register group: program counter, jump register, double-buffered output register and a sampled
// input register, with a priority-muxed load bus. Define REGS_BANK_BUSERR_EN for the conflict monitor.
module regs_bank_v2 #(
  parameter int unsigned W     = 4,
  parameter int unsigned N     = 2,
  parameter int unsigned SEL_W = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [W-1:0]     STOREBUS,
  input  logic [SEL_W-1:0] ST_SEL,
  input  logic             JR_ST,
  input  logic             OR_ST,
  input  logic             OR_COMMIT,
  input  logic             PC_LD,
  input  logic             PC_INC,
  input  logic [SEL_W-1:0] LD_SEL,
  input  logic             JR_OUT,
  input  logic             IR_OUT,
  input  logic             ERR_CLR,
  input  logic [N*W-1:0]   IR,
  output logic [W-1:0]     LOADBUS,
  output logic             LD_VLD,
  output logic [N*W-1:0]   PA,
  output logic             PC_WRAP,
  output logic [N*W-1:0]   OR,
  output logic             OR_UPD,
  output logic             IR_CHG,
  output logic             BUS_ERR
);

  localparam int unsigned WA = N * W;

  logic [WA-1:0] pc_q, jr_q, jr_d, stg_q, stg_d, or_q, ir_q;
  logic          wrap_q, or_upd_q, ir_chg_q, armed_q;
  logic [W-1:0]  jr_nib, ir_nib, ld_data;

  // Nibble writes and reads; indices outside 0..N-1 never match, so they are ignored / read 0.
  always_comb begin
    jr_d   = jr_q;
    stg_d  = stg_q;
    jr_nib = '0;
    ir_nib = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (JR_ST && ST_SEL == SEL_W'(k)) jr_d[k*W +: W] = STOREBUS;
      if (OR_ST && ST_SEL == SEL_W'(k)) stg_d[k*W +: W] = STOREBUS;
      if (LD_SEL == SEL_W'(k)) begin
        jr_nib = jr_q[k*W +: W];
        ir_nib = ir_q[k*W +: W];
      end
    end
  end

  always_comb begin
    ld_data = '0;
    if (JR_OUT)      ld_data = jr_nib;
    else if (IR_OUT) ld_data = ir_nib;
  end

  assign LOADBUS = ld_data;
  assign LD_VLD  = JR_OUT | IR_OUT;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc_q     <= '0;
      jr_q     <= '0;
      stg_q    <= '0;
      or_q     <= '0;
      ir_q     <= '0;
      wrap_q   <= 1'b0;
      or_upd_q <= 1'b0;
      ir_chg_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      jr_q  <= jr_d;
      stg_q <= stg_d;
      // Commit uses the next staging value so a same-cycle OR_ST writes through.
      if (OR_COMMIT) or_q <= stg_d;
      or_upd_q <= OR_COMMIT;
      if (PC_LD) begin
        pc_q   <= jr_q;
        wrap_q <= 1'b0;
      end else if (PC_INC) begin
        pc_q   <= pc_q + WA'(1);
        wrap_q <= &pc_q;
      end else begin
        wrap_q <= 1'b0;
      end
      ir_q     <= IR;
      // First edge after reset only primes ir_q; no change pulse.
      ir_chg_q <= armed_q && (IR != ir_q);
      armed_q  <= 1'b1;
    end
  end

  assign PA      = pc_q;
  assign PC_WRAP = wrap_q;
  assign OR      = or_q;
  assign OR_UPD  = or_upd_q;
  assign IR_CHG  = ir_chg_q;

`ifdef REGS_BANK_BUSERR_EN
  logic err_q, st_bad, ld_bad, err_set;

  assign st_bad  = 32'(ST_SEL) >= N;
  assign ld_bad  = 32'(LD_SEL) >= N;
  assign err_set = (JR_OUT & IR_OUT) | ((JR_ST | OR_ST) & st_bad) | ((JR_OUT | IR_OUT) & ld_bad);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_set | (err_q & ~ERR_CLR);
    end
  end

  assign BUS_ERR = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = ERR_CLR;
  assign BUS_ERR        = 1'b0;
`endif

endmodule
